// File: rtl/divider_pkg.sv
// +----------------------------------------------------------------------+
// | divider_pkg : shared FSM state type and counter sizing for divider   |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

package divider_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Bits needed to count 0..width retired quotient bits
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/divider_step.sv
// +----------------------------------------------------------------------+
// | divider_step : one restoring shift/compare/subtract iteration        |
// | Revision     : 1.0                                                   |
// +----------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module divider_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH:0]   i_rem,
    input  logic             i_bit,
    input  logic [WIDTH-1:0] i_dvs,
    output logic [WIDTH:0]   o_rem,
    output logic             o_qbit
);

    logic [WIDTH+1:0] w_shift;
    logic [WIDTH+1:0] w_dvs;

    assign w_shift = {i_rem, i_bit};
    assign w_dvs   = {2'b00, i_dvs};
    assign o_qbit  = (w_shift >= w_dvs);
    // On a successful subtract the difference is below the divisor, so it fits
    assign o_rem   = o_qbit ? (WIDTH+1)'(w_shift - w_dvs) : w_shift[WIDTH:0];

endmodule

`default_nettype wire

// File: rtl/divider.sv
// +----------------------------------------------------------------------+
// | divider  : multi-cycle unsigned restoring divider, WIDTH cycles/op   |
// |            DIVIDER_SVA_EN compiles in protocol/result assertions     |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module divider
    import divider_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             start,
    output logic             busy,
    output logic             val,
    output logic             dbz,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    input  logic             rst_n
);

    localparam int                 c_cnt_w = cnt_width(WIDTH);
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(WIDTH - 1);

    state_t             r_state;
    state_t             w_next;
    logic [c_cnt_w-1:0] r_cnt;
    logic [WIDTH:0]     r_rem;
    logic [WIDTH-1:0]   r_dvd;
    logic [WIDTH-1:0]   r_dvs;
    logic [WIDTH:0]     w_rem_nxt;
    logic               w_qbit;
    logic               w_accept;
    logic               w_zero;
    logic               w_last;

    divider_step #(.WIDTH(WIDTH)) u_step (
        .i_rem  (r_rem),
        .i_bit  (r_dvd[WIDTH-1]),
        .i_dvs  (r_dvs),
        .o_rem  (w_rem_nxt),
        .o_qbit (w_qbit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next = BUSY;
            BUSY:    if (w_last)   w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        w_accept = 1'b0;
        w_zero   = 1'b0;
        w_last   = 1'b0;
        if (r_state == IDLE) begin
            w_accept = start && (y != '0);
            w_zero   = start && (y == '0);
        end else begin
            w_last   = (r_cnt == c_last);
        end
    end

    // r_dvd doubles as the quotient accumulator: dividend bits shift out the top
    // while quotient bits shift in at the bottom.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_rem <= '0;
            r_dvd <= '0;
            r_dvs <= '0;
            busy  <= 1'b0;
            val   <= 1'b0;
            dbz   <= 1'b0;
            q     <= '0;
            r     <= '0;
        end else if (w_accept) begin
            r_cnt <= '0;
            r_rem <= '0;
            r_dvd <= x;
            r_dvs <= y;
            busy  <= 1'b1;
            val   <= 1'b0;
            dbz   <= 1'b0;
        end else if (w_zero) begin
            dbz   <= 1'b1;
            val   <= 1'b0;
        end else if (r_state == BUSY) begin
            r_cnt <= r_cnt + c_cnt_w'(1);
            r_rem <= w_rem_nxt;
            r_dvd <= {r_dvd[WIDTH-2:0], w_qbit};
            if (w_last) begin
                q    <= {r_dvd[WIDTH-2:0], w_qbit};
                r    <= w_rem_nxt[WIDTH-1:0];
                val  <= 1'b1;
                busy <= 1'b0;
            end
        end
    end

`ifdef DIVIDER_SVA_EN
    logic [WIDTH-1:0]   r_sva_x;
    logic [2*WIDTH-1:0] w_sva_chk;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sva_x <= '0;
        end else if (w_accept) begin
            r_sva_x <= x;
        end
    end

    assign w_sva_chk = (2*WIDTH)'(q) * (2*WIDTH)'(r_dvs) + (2*WIDTH)'(r);

    a_busy_val: assert property (@(posedge clk) disable iff (!rst_n) !(busy && val));
    // val is updated on the WIDTH-th edge and therefore observed one sample later
    a_latency:  assert property (@(posedge clk) disable iff (!rst_n)
                                 w_accept |-> ##(WIDTH + 1) $rose(val));
    a_result:   assert property (@(posedge clk) disable iff (!rst_n)
                                 $rose(val) |-> (w_sva_chk == (2*WIDTH)'(r_sva_x)) && (r < r_dvs));
    a_dbz_idle: assert property (@(posedge clk) disable iff (!rst_n) dbz |-> !busy);
`endif

endmodule

`default_nettype wire

// File: tb/tb_divider.sv
// +----------------------------------------------------------------------+
// | tb_divider : scoreboard bench for divider (queue + decoupled monitor)|
// | Revision   : 1.0                                                     |
// +----------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_divider;

    localparam int WIDTH = 8;

    typedef struct {
        logic [WIDTH-1:0] q;
        logic [WIDTH-1:0] r;
        bit               dbz;
        int               t;
        string            name;
    } exp_t;

    logic             clk   = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [WIDTH-1:0] x     = '0;
    logic [WIDTH-1:0] y     = '0;
    logic             busy;
    logic             val;
    logic             dbz;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;

    exp_t             sb[$];
    int               checks = 0;
    int               errors = 0;
    int               cyc    = 0;
    logic [WIDTH-1:0] last_q = '0;
    logic [WIDTH-1:0] last_r = '0;

    divider #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .start (start),
        .busy  (busy),
        .val   (val),
        .dbz   (dbz),
        .x     (x),
        .y     (y),
        .q     (q),
        .r     (r),
        .rst_n (rst_n)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    // Expected result of a request that the DUT should accept on the coming edge
    task automatic push_exp(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input string nm);
        exp_t e;
        e.t    = cyc + 1;
        e.name = nm;
        if (b == '0) begin
            e.dbz = 1'b1;
            e.q   = last_q;
            e.r   = last_r;
        end else begin
            e.dbz  = 1'b0;
            e.q    = a / b;
            e.r    = a % b;
            last_q = e.q;
            last_r = e.r;
        end
        sb.push_back(e);
    endtask

    // Called at negedge+1; returns at negedge+1 with start low
    task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input string nm);
        x     = a;
        y     = b;
        start = 1'b1;
        push_exp(a, b, nm);
        @(negedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 40; i++) begin
            if (sb.size() == 0) break;
            @(negedge clk); #1;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL timeout: %0d results still pending, first %s", sb.size(), sb[0].name);
            sb.delete();
        end
    endtask

    // Monitor: a result is presented when val rises or dbz rises
    initial begin
        logic pv;
        logic pd;
        exp_t e;
        int   lat;
        int   elat;
        pv = 1'b0;
        pd = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && ((val && !pv) || (dbz && !pd))) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_result: got q=%0d r=%0d val=%0b dbz=%0b, required none", q, r, val, dbz);
                end else begin
                    e    = sb.pop_front();
                    lat  = cyc - e.t;
                    elat = e.dbz ? 0 : WIDTH;
                    if (q !== e.q || r !== e.r || val !== !e.dbz || dbz !== e.dbz || busy !== 1'b0 || lat != elat) begin
                        errors++;
                        $display("FAIL %s: got q=%0d r=%0d val=%0b dbz=%0b busy=%0b lat=%0d, required q=%0d r=%0d val=%0b dbz=%0b busy=0 lat=%0d",
                                 e.name, q, r, val, dbz, busy, lat, e.q, e.r, !e.dbz, e.dbz, elat);
                    end
                end
            end
            pv = val;
            pd = dbz;
        end
    end

    initial begin
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] bx[6];
        logic [WIDTH-1:0] by[6];
        int               n;
        bx = '{8'd255, 8'd0, 8'd254, 8'd128, 8'd1,   8'd255};
        by = '{8'd255, 8'd5, 8'd255, 8'd16,  8'd255, 8'd2};

        repeat (3) @(negedge clk);
        #1;
        chk("reset_busy", 32'(busy), 0);
        chk("reset_val",  32'(val),  0);
        chk("reset_dbz",  32'(dbz),  0);
        chk("reset_q",    32'(q),    0);
        chk("reset_r",    32'(r),    0);

        // First start lands on the first edge after reset release
        rst_n = 1'b1;
        issue(8'd11, 8'd3, "div_11_3");
        wait_done();
        issue(8'd10, 8'd0, "dbz_10_0");
        wait_done();
        issue(8'd248, 8'd254, "div_248_254_after_dbz");
        wait_done();

        // A second start mid-division, with operands changed, must be ignored
        issue(8'd255, 8'd1, "div_255_1_ignore_busy_start");
        @(negedge clk); #1;
        x     = 8'd7;
        y     = 8'd2;
        start = 1'b1;
        @(negedge clk); #1;
        start = 1'b0;
        x     = '0;
        y     = '0;
        wait_done();
        repeat (12) @(negedge clk);
        #1;

        // start held through completion is taken one edge later
        x     = 8'd20;
        y     = 8'd3;
        start = 1'b1;
        push_exp(8'd20, 8'd3, "held_start_first");
        @(negedge clk); #1;
        n = 0;
        while (!val && n < 40) begin
            @(negedge clk); #1;
            n++;
        end
        if (!val) begin
            checks++;
            errors++;
            $display("FAIL held_start_timeout: got val=0 after %0d cycles, required val=1", n);
            sb.delete();
        end else begin
            x = 8'd100;
            y = 8'd9;
            push_exp(8'd100, 8'd9, "held_start_second");
        end
        @(negedge clk); #1;
        start = 1'b0;
        wait_done();

        // Reset mid-division aborts with outputs cleared at once
        issue(8'd100, 8'd3, "aborted");
        repeat (3) @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_val",  32'(val),  0);
        chk("abort_q",    32'(q),    0);
        chk("abort_r",    32'(r),    0);
        sb.delete();
        last_q = '0;
        last_r = '0;
        @(negedge clk); #1;
        rst_n = 1'b1;
        issue(8'd200, 8'd7, "div_200_7_after_reset");
        wait_done();

        for (int i = 0; i < 6; i++) begin
            issue(bx[i], by[i], $sformatf("boundary_%0d_%0d", bx[i], by[i]));
            wait_done();
        end

        for (int i = 0; i < 1000; i++) begin
            a = WIDTH'($urandom_range(0, 255));
            b = WIDTH'($urandom_range(1, 255));
            issue(a, b, $sformatf("sweep_%0d_%0d", a, b));
            wait_done();
        end

        repeat (12) @(negedge clk);
        #1;
        chk("queue_empty", 32'(sb.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
